// File: rtl/mem_access_stage_pkg.sv
// rtl/mem_access_stage_pkg.sv - MEM stage bus widths, field positions and load op encoding
package mem_access_stage_pkg;

   localparam int ES_BUS_W         = 80;
   localparam int CSR_BUS_W        = 97;
   localparam int WS_BUS_W         = 71;
   localparam int FWD_W            = 40;
   localparam int CANCEL_W_DEFAULT = 2;

   localparam int CSR_EX_BIT   = 90;
   localparam int CSR_ERTN_BIT = 91;

   // one-hot ld_op bit positions
   localparam int LD_B  = 0;
   localparam int LD_H  = 1;
   localparam int LD_W  = 2;
   localparam int LD_BU = 3;
   localparam int LD_HU = 4;

   typedef struct packed {
      logic        ale;
      logic        meaningful;
      logic [2:0]  mem_we;
      logic [4:0]  ld_op;
      logic        gr_we;
      logic [4:0]  dest;
      logic [31:0] result;
      logic [31:0] pc;
   } es_to_ms_t;

   typedef struct packed {
      logic        meaningful;
      logic        gr_we;
      logic [4:0]  dest;
      logic [31:0] final_result;
      logic [31:0] pc;
   } ms_to_ws_t;

endpackage

// File: rtl/mem_access_stage_load_ext.sv
// rtl/mem_access_stage_load_ext.sv - combinational load lane select and sign/zero extension
module mem_access_stage_load_ext
   import mem_access_stage_pkg::*;
(
   input  logic [4:0]  op,
   input  logic [1:0]  addr,
   input  logic [31:0] rdata,
   output logic [31:0] result
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v = rdata[{addr, 3'b000} +: 8];
      half_v = addr[1] ? rdata[31:16] : rdata[15:0];
      result = rdata;
      if (op[LD_B])       result = {{24{byte_v[7]}}, byte_v};
      else if (op[LD_BU]) result = {24'b0, byte_v};
      else if (op[LD_H])  result = {{16{half_v[15]}}, half_v};
      else if (op[LD_HU]) result = {16'b0, half_v};
      else if (op[LD_W])  result = rdata;
   end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage: waits for data_ok, extends loads, drops stale responses
module mem_access_stage
   import mem_access_stage_pkg::*;
#(
   parameter int CANCEL_W = CANCEL_W_DEFAULT
)
(
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 es_to_ms_valid,
   input  logic [ES_BUS_W-1:0]  es_to_ms_bus,
   input  logic [CSR_BUS_W-1:0] es_to_ms_csr_bus,
   input  logic                 es_req_fire,
   output logic                 ms_allowin,
   input  logic                 ws_allowin,
   output logic                 ms_to_ws_valid,
   output logic [WS_BUS_W-1:0]  ms_to_ws_bus,
   output logic [CSR_BUS_W-1:0] ms_to_ws_csr_bus,
   input  logic                 data_sram_data_ok,
   input  logic [31:0]          data_sram_rdata,
   input  logic                 wb_flush,
   output logic [FWD_W-1:0]     ms_forward,
   output logic                 ms_ex,
   output logic                 ms_ertn
);

   localparam logic [CANCEL_W:0] CNT_MAX = {1'b0, {CANCEL_W{1'b1}}};

   es_to_ms_t            es_in;
   logic                 ms_valid;
   logic                 need_resp;
   logic                 meaningful_r;
   logic [4:0]           ld_op_r;
   logic                 gr_we_r;
   logic [4:0]           dest_r;
   logic [31:0]          result_r;
   logic [31:0]          pc_r;
   logic [CSR_BUS_W-1:0] csr_r;
   logic                 rdata_buf_valid;
   logic [31:0]          rdata_buf;
   logic [CANCEL_W-1:0]  cancel_cnt;
   logic [CANCEL_W:0]    cnt_next;

   logic        exc;
   logic        fresh_ok;
   logic        stale_ok;
   logic        ms_ready_go;
   logic        wait_inflight;
   logic        is_load;
   logic        gr_we_eff;
   logic        load_pending;
   logic [31:0] rdata_sel;
   logic [31:0] ext_data;
   logic [31:0] final_result;
   ms_to_ws_t   ws_bus;

   assign es_in    = es_to_ms_bus;
   assign exc      = csr_r[CSR_EX_BIT];
   assign fresh_ok = data_sram_data_ok & (cancel_cnt == '0);
   assign stale_ok = data_sram_data_ok & (cancel_cnt != '0);

   assign ms_ready_go = ~need_resp | exc | rdata_buf_valid | fresh_ok;
   assign ms_allowin  = ~ms_valid | (ms_ready_go & ws_allowin);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ms_valid     <= 1'b0;
         need_resp    <= 1'b0;
         meaningful_r <= 1'b0;
         ld_op_r      <= '0;
         gr_we_r      <= 1'b0;
         dest_r       <= '0;
         result_r     <= '0;
         pc_r         <= '0;
         csr_r        <= '0;
      end else begin
         if (wb_flush)        ms_valid <= 1'b0;
         else if (ms_allowin) ms_valid <= es_to_ms_valid;
         if (es_to_ms_valid && ms_allowin) begin
            need_resp    <= ((|es_in.ld_op) | (|es_in.mem_we)) & ~es_in.ale
                            & ~es_to_ms_csr_bus[CSR_EX_BIT];
            meaningful_r <= es_in.meaningful;
            ld_op_r      <= es_in.ld_op;
            gr_we_r      <= es_in.gr_we;
            dest_r       <= es_in.dest;
            result_r     <= es_in.result;
            pc_r         <= es_in.pc;
            csr_r        <= es_to_ms_csr_bus;
         end
      end
   end

   // Holds the response only while WB is stalling; cleared whenever the stage advances.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rdata_buf_valid <= 1'b0;
         rdata_buf       <= '0;
      end else if (ms_allowin) begin
         rdata_buf_valid <= 1'b0;
      end else if (ms_valid && need_resp && !rdata_buf_valid && fresh_ok) begin
         rdata_buf_valid <= 1'b1;
         rdata_buf       <= data_sram_rdata;
      end
   end

   // Requests still in flight when WB flushes owe us responses nobody wants.
   assign wait_inflight = ms_valid & need_resp & ~rdata_buf_valid & ~fresh_ok;

   always_comb begin
      cnt_next = {1'b0, cancel_cnt};
      if (wb_flush)
         cnt_next = cnt_next + (CANCEL_W+1)'(wait_inflight) + (CANCEL_W+1)'(es_req_fire);
      cnt_next = cnt_next - (CANCEL_W+1)'(stale_ok);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)               cancel_cnt <= '0;
      else if (cnt_next > CNT_MAX) cancel_cnt <= '1;
      else                       cancel_cnt <= cnt_next[CANCEL_W-1:0];
   end

   assign rdata_sel = rdata_buf_valid ? rdata_buf : data_sram_rdata;

   mem_access_stage_load_ext u_load_ext (
      .op     (ld_op_r),
      .addr   (result_r[1:0]),
      .rdata  (rdata_sel),
      .result (ext_data)
   );

   assign is_load      = |ld_op_r;
   assign final_result = (is_load & ~exc) ? ext_data : result_r;
   assign gr_we_eff    = gr_we_r & ~exc;
   assign load_pending = is_load & ~exc & ~ms_ready_go;

   always_comb begin
      ws_bus.meaningful   = meaningful_r;
      ws_bus.gr_we        = gr_we_eff;
      ws_bus.dest         = dest_r;
      ws_bus.final_result = final_result;
      ws_bus.pc           = pc_r;
   end

   assign ms_to_ws_bus     = ws_bus;
   assign ms_to_ws_csr_bus = csr_r;
   assign ms_to_ws_valid   = ms_valid & ms_ready_go & ~wb_flush;
   assign ms_forward       = ms_valid ? {1'b1, load_pending, gr_we_eff, dest_r, final_result}
                                      : '0;
   assign ms_ex            = ms_valid & exc;
   assign ms_ertn          = ms_valid & csr_r[CSR_ERTN_BIT];

endmodule
